demux_1x3_reg: RTL and testbench

- Registered 1-to-3 demultiplexer: the routing counterpart of the 3-input datapath select mux.
- Steers one input stream to one of three destinations using the same 2-bit select encoding: 00, 01, 10.
- Each destination has a one-entry holding register with a valid/ready handshake, so a slow consumer stalls only the beats routed to it.
- Select code 11 is illegal. Such a beat is consumed, discarded and counted.
- Sits between the execute/write-back datapath and the per-destination consumers.

---
 rtl/demux_1x3_if.sv | 38 +++
 rtl/demux_1x3_reg.sv | 105 ++++++++++
 tb/tb_demux_1x3_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demux_1x3_if.sv
// Handshake bundle for the registered 1-to-3 demultiplexer: one upstream
// stream in, three valid/ready destinations out.
interface demux_1x3_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            select_1x3;
    logic                  in_valid;
    logic                  in_ready;

    logic [DATA_WIDTH-1:0] out_00_data;
    logic [DATA_WIDTH-1:0] out_01_data;
    logic [DATA_WIDTH-1:0] out_10_data;
    logic                  out_00_valid;
    logic                  out_01_valid;
    logic                  out_10_valid;
    logic                  out_00_ready;
    logic                  out_01_ready;
    logic                  out_10_ready;

    // Environment side: drives the input stream and the consumer readies.
    modport master (
        output in_data, select_1x3, in_valid,
        output out_00_ready, out_01_ready, out_10_ready,
        input  in_ready,
        input  out_00_data, out_01_data, out_10_data,
        input  out_00_valid, out_01_valid, out_10_valid
    );

    // Demux side.
    modport slave (
        input  in_data, select_1x3, in_valid,
        input  out_00_ready, out_01_ready, out_10_ready,
        output in_ready,
        output out_00_data, out_01_data, out_10_data,
        output out_00_valid, out_01_valid, out_10_valid
    );
endinterface

// File: rtl/demux_1x3_reg.sv
// Registered 1-to-3 demultiplexer with a one-entry holding register per
// destination; select code 11 beats are consumed, dropped and counted.
module demux_1x3_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    demux_1x3_if.slave           bus,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    logic [2:0]            slot_ready;
    logic [2:0]            slot_free;
    logic [2:0]            valid_arr;
    logic [DATA_WIDTH-1:0] data_arr [3];
    logic                  accept;

    assign slot_ready = {bus.out_10_ready, bus.out_01_ready, bus.out_00_ready};

    // in_ready looks only at the addressed slot, so a stalled consumer
    // never blocks beats headed elsewhere.
    always_comb begin
        bus.in_ready = 1'b1;
        case (bus.select_1x3)
            2'b00:   bus.in_ready = slot_free[0];
            2'b01:   bus.in_ready = slot_free[1];
            2'b10:   bus.in_ready = slot_free[2];
            default: bus.in_ready = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : slot_g
            logic                  valid_q, valid_d;
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  write;

            always_comb begin
                slot_free[gi] = !valid_q || slot_ready[gi];
                write         = accept && (bus.select_1x3 == 2'(gi));
                valid_d       = valid_q;
                data_d        = data_q;
                if (write) begin
                    // A same-cycle drain and refill keeps valid high: no bubble.
                    valid_d = 1'b1;
                    data_d  = bus.in_data;
                end else if (valid_q && slot_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign valid_arr[gi] = valid_q;
            assign data_arr[gi]  = data_q;
        end
    endgenerate

    assign bus.out_00_valid = valid_arr[0];
    assign bus.out_01_valid = valid_arr[1];
    assign bus.out_10_valid = valid_arr[2];
    assign bus.out_00_data  = data_arr[0];
    assign bus.out_01_data  = data_arr[1];
    assign bus.out_10_data  = data_arr[2];

    logic                 drop_pulse_q, drop_pulse_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                 illegal_accept;

    always_comb begin
        illegal_accept = accept && (bus.select_1x3 == SEL_ILLEGAL);
        drop_pulse_d   = illegal_accept;
        drop_count_d   = drop_count_q;
        if (illegal_accept && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_demux_1x3_reg.sv
// Directed bench for demux_1x3_reg: routing, back-pressure, illegal-select
// counting with saturation, and reset priority.
module tb_demux_1x3_reg;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          drop_pulse;
    logic [CW-1:0] drop_count;
    int            pass_cnt  = 0;
    int            total_cnt = 0;

    demux_1x3_if #(.DATA_WIDTH(DW)) bus ();

    demux_1x3_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
        bus.in_valid   = 1'b1;
        bus.select_1x3 = sel;
        bus.in_data    = d;
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.select_1x3   = 2'b00;
        bus.in_data      = '0;
        bus.out_00_ready = 1'b1;
        bus.out_01_ready = 1'b1;
        bus.out_10_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_v00", 32'(bus.out_00_valid), 32'd0);
        chk("rst_v01", 32'(bus.out_01_valid), 32'd0);
        chk("rst_v10", 32'(bus.out_10_valid), 32'd0);
        chk("rst_d00", 32'(bus.out_00_data), 32'd0);
        chk("rst_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_count", 32'(drop_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Route one beat to each destination, all consumers ready.
        send(2'b00, 16'h1111);
        #1 chk("route_rdy00", 32'(bus.in_ready), 32'd1);
        step();
        chk("route_v00", 32'(bus.out_00_valid), 32'd1);
        chk("route_d00", 32'(bus.out_00_data), 32'h1111);
        send(2'b01, 16'h2222);
        #1 chk("route_rdy01", 32'(bus.in_ready), 32'd1);
        step();
        chk("route_v01", 32'(bus.out_01_valid), 32'd1);
        chk("route_d01", 32'(bus.out_01_data), 32'h2222);
        chk("route_v00_drained", 32'(bus.out_00_valid), 32'd0);
        send(2'b10, 16'h3333);
        #1 chk("route_rdy10", 32'(bus.in_ready), 32'd1);
        step();
        chk("route_v10", 32'(bus.out_10_valid), 32'd1);
        chk("route_d10", 32'(bus.out_10_data), 32'h3333);
        bus.in_valid = 1'b0;
        step();
        chk("route_v10_drained", 32'(bus.out_10_valid), 32'd0);
        chk("route_d10_hold", 32'(bus.out_10_data), 32'h3333);

        // Back-pressure on slot 01, then same-cycle drain and refill.
        bus.out_01_ready = 1'b0;
        send(2'b01, 16'h00AA);
        step();
        chk("bp_v01", 32'(bus.out_01_valid), 32'd1);
        chk("bp_d01", 32'(bus.out_01_data), 32'h00AA);
        send(2'b01, 16'h00BB);
        #1 chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp_d01_stable", 32'(bus.out_01_data), 32'h00AA);
        chk("bp_v01_stable", 32'(bus.out_01_valid), 32'd1);
        bus.out_01_ready = 1'b1;
        #1 chk("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_refill_d01", 32'(bus.out_01_data), 32'h00BB);
        chk("bp_refill_v01", 32'(bus.out_01_valid), 32'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_final_v01", 32'(bus.out_01_valid), 32'd0);

        // A stalled slot 10 must not block slot 00.
        bus.out_10_ready = 1'b0;
        send(2'b10, 16'hC0DE);
        step();
        chk("iso_v10", 32'(bus.out_10_valid), 32'd1);
        send(2'b00, 16'h5A5A);
        #1 chk("iso_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("iso_v00", 32'(bus.out_00_valid), 32'd1);
        chk("iso_d00", 32'(bus.out_00_data), 32'h5A5A);
        chk("iso_d10", 32'(bus.out_10_data), 32'hC0DE);
        chk("iso_v10_held", 32'(bus.out_10_valid), 32'd1);

        // Three back-to-back illegal beats.
        send(2'b11, 16'hDEAD);
        #1 chk("ill_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("ill_pulse1", 32'(drop_pulse), 32'd1);
        chk("ill_count1", 32'(drop_count), 32'd1);
        chk("ill_v00_drained", 32'(bus.out_00_valid), 32'd0);
        step();
        chk("ill_pulse2", 32'(drop_pulse), 32'd1);
        chk("ill_count2", 32'(drop_count), 32'd2);
        step();
        chk("ill_pulse3", 32'(drop_pulse), 32'd1);
        chk("ill_count3", 32'(drop_count), 32'd3);
        bus.in_valid = 1'b0;
        step();
        chk("ill_pulse_off", 32'(drop_pulse), 32'd0);
        chk("ill_count_hold", 32'(drop_count), 32'd3);
        chk("ill_v00", 32'(bus.out_00_valid), 32'd0);
        chk("ill_v01", 32'(bus.out_01_valid), 32'd0);
        chk("ill_v10", 32'(bus.out_10_valid), 32'd1);
        chk("ill_d10", 32'(bus.out_10_data), 32'hC0DE);

        // Saturation: bring count to 254, then three more beats.
        send(2'b11, 16'h0000);
        for (int i = 0; i < 251; i++) step();
        bus.in_valid = 1'b0;
        step();
        chk("sat_count254", 32'(drop_count), 32'd254);
        send(2'b11, 16'h0000);
        step();
        step();
        step();
        bus.in_valid = 1'b0;
        chk("sat_count255", 32'(drop_count), 32'd255);
        step();
        chk("sat_count_stays", 32'(drop_count), 32'd255);

        // Fill every slot, then reset alongside a would-be accepted beat.
        bus.out_00_ready = 1'b0;
        bus.out_01_ready = 1'b0;
        send(2'b00, 16'h0A0A);
        step();
        send(2'b01, 16'h0B0B);
        step();
        bus.in_valid = 1'b0;
        chk("full_v00", 32'(bus.out_00_valid), 32'd1);
        chk("full_v01", 32'(bus.out_01_valid), 32'd1);
        chk("full_v10", 32'(bus.out_10_valid), 32'd1);
        bus.out_00_ready = 1'b1;
        send(2'b00, 16'hFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_00_ready = 1'b0;
        chk("rr_v00", 32'(bus.out_00_valid), 32'd0);
        chk("rr_v01", 32'(bus.out_01_valid), 32'd0);
        chk("rr_v10", 32'(bus.out_10_valid), 32'd0);
        chk("rr_d00", 32'(bus.out_00_data), 32'd0);
        chk("rr_d01", 32'(bus.out_01_data), 32'd0);
        chk("rr_d10", 32'(bus.out_10_data), 32'd0);
        chk("rr_count", 32'(drop_count), 32'd0);
        chk("rr_pulse", 32'(drop_pulse), 32'd0);
        step();
        chk("rr_not_captured", 32'(bus.out_00_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
